pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register for the core's decode→execute and later stage boundaries.
- Replaces fixed stall-vector stage registers with a per-stage valid/ready handshake and a 2-entry skid buffer, so upstream can be back-pressured without a combinational ready path.
- Supports flush (branch redirect), global rdy freeze, and x0 write-request squash.
- Exports occupancy and a saturating bubble counter for performance debug.

Parameters:
- PAYLOAD_W, 96, width of opaque stage payload (aluop, operands, pc, offset, taken packed by the instantiating stage).
- REG_ADDR_W, 5, destination register address width.
- NOP_PAYLOAD, 0, payload value driven while the stage is empty (must decode as EX_NOP).
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global enable; 0 freezes all state
- flush  in  1  discard all held entries (branch redirect)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_payload  in  PAYLOAD_W  upstream payload
- in_w_req  in  1  upstream register-write request
- in_w_addr  in  REG_ADDR_W  upstream destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_payload  out  PAYLOAD_W  head payload, NOP_PAYLOAD when empty
- out_w_req  out  1  head write request, 0 when empty
- out_w_addr  out  REG_ADDR_W  head destination, 0 when empty
- occupancy  out  2  entries held (0..2)
- bubble_cnt  out  CNT_W  saturating count of empty cycles

Behaviour:
- Storage: main register (head) and skid register, each with a valid bit.
- Outputs out_* are driven directly from the main register, with no combinational path from in_* to out_*.
- in_ready = rdy & !skid_valid & !flush. It is a function of registered state and rdy/flush only, never of out_ready.
- accept = in_valid & in_ready. consume = out_valid & out_ready & rdy.
- On capture, the stored w_req = in_w_req & (in_w_addr != 0). A write to x0 is never requested downstream.
- Reset (asynchronous):
  - both valid bits 0
  - main payload = NOP_PAYLOAD, w_req 0, w_addr 0
  - skid contents 0
  - bubble_cnt 0
- rdy=0: no state changes at all, including bubble_cnt. Outputs hold their values.
- flush=1 (with rdy=1): both valid bits cleared; main contents forced to NOP/0/0. No accept that cycle, regardless of in_valid. Flush takes priority over consume and accept. The consume handshake is still considered to have occurred from the downstream's view; downstream must itself ignore the entry on redirect.
- Otherwise, at the clock edge:
  - main empty, skid empty, accept → entry to main.
  - main full, skid empty, consume & accept → entry to main.
  - main full, skid empty, !consume & accept → entry to skid.
  - main full, skid empty, consume & !accept → main becomes empty (NOP values).
  - main full, skid full, consume → skid moves to main, skid empties. No accept is possible, since in_ready=0.
  - main full, skid full, !consume → hold.
- Main empty with skid full is unreachable; an assertion flags it.
- Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 entry/cycle with out_ready held at 1. Entry order is strictly FIFO.
- occupancy = main_valid + skid_valid, registered state.
- bubble_cnt increments by 1 on each rdy=1 cycle in which out_valid=0 (before the edge). It saturates at all-ones and clears only on rst.

Test Plan:
- Streaming:
  - Stimulus: rst pulse, then in_valid=1 and out_ready=1 for 4 cycles, payloads A,B,C,D.
  - Response: out_payload shows A,B,C,D on consecutive cycles starting 1 cycle after the first accept; occupancy stays 1; in_ready=1 throughout.
- Backpressure:
  - Stimulus: out_ready=0 while A,B are offered.
  - Response: occupancy reaches 2; in_ready=0; C is held upstream. After raising out_ready, the order out is A,B,C, and in_ready returns to 1 the cycle after A is consumed.
- x0 squash:
  - Stimulus: in_w_req=1 with in_w_addr=0.
  - Response: out_w_req=0.
  - Stimulus: in_w_req=1 with in_w_addr=5.
  - Response: out_w_req=1, out_w_addr=5.
- Flush with two entries held and in_valid=1:
  - Response: next cycle out_valid=0, out_payload=NOP_PAYLOAD, occupancy=0; the offered entry is not captured; in_ready=0 during the flush cycle.
- rdy freeze plus async reset:
  - Stimulus: hold rdy=0 for 3 cycles with in_valid=1.
  - Response: no state or bubble_cnt change.
  - Stimulus: assert rst mid-cycle while occupancy=2.
  - Response: outputs go to reset values immediately, without waiting for a clock edge.
- Bubble counter:
  - Stimulus: CNT_W=2, 5 idle cycles with rdy=1.
  - Response: bubble_cnt = 3 (saturated), not wrapping.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
//
// The head (main) register drives out_* directly. The skid register catches the
// one entry that can arrive in the cycle the downstream stalls. Because of that,
// in_ready depends only on registered state and rdy/flush, and never on out_ready.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   rdy             global enable; 0 freezes every flop including bubble_cnt
//   flush           drop all held entries (branch redirect)
//   in_*            upstream valid/ready handshake, payload, write request/address
//   out_*           head entry handshake, payload, write request/address
//                   (NOP_PAYLOAD/0/0 when empty)
//   occupancy       entries held (0..2)
//   bubble_cnt      saturating count of rdy cycles with no valid head
module pipe_stage_skid #(
  parameter int unsigned           PAYLOAD_W   = 96,
  parameter int unsigned           REG_ADDR_W  = 5,
  parameter logic [PAYLOAD_W-1:0]  NOP_PAYLOAD = '0,
  parameter int unsigned           CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic                  in_w_req,
  input  logic [REG_ADDR_W-1:0] in_w_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic                  out_w_req,
  output logic [REG_ADDR_W-1:0] out_w_addr,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic                  main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0]  main_payload_q, main_payload_d;
  logic                  main_w_req_q, main_w_req_d;
  logic [REG_ADDR_W-1:0] main_w_addr_q, main_w_addr_d;

  logic                  skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0]  skid_payload_q, skid_payload_d;
  logic                  skid_w_req_q, skid_w_req_d;
  logic [REG_ADDR_W-1:0] skid_w_addr_q, skid_w_addr_d;

  logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

  logic accept;
  logic consume;
  logic cap_w_req;

  assign in_ready = rdy & ~skid_valid_q & ~flush;
  assign accept   = in_valid & in_ready;
  assign consume  = main_valid_q & out_ready & rdy;

  // Writes to x0 are dropped at capture so downstream never sees them.
  assign cap_w_req = in_w_req & (in_w_addr != '0);

  always_comb begin
    main_valid_d   = main_valid_q;
    main_payload_d = main_payload_q;
    main_w_req_d   = main_w_req_q;
    main_w_addr_d  = main_w_addr_q;
    skid_valid_d   = skid_valid_q;
    skid_payload_d = skid_payload_q;
    skid_w_req_d   = skid_w_req_q;
    skid_w_addr_d  = skid_w_addr_q;
    bubble_cnt_d   = bubble_cnt_q;

    if (rdy) begin
      if (!main_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end

      if (flush) begin
        main_valid_d   = 1'b0;
        main_payload_d = NOP_PAYLOAD;
        main_w_req_d   = 1'b0;
        main_w_addr_d  = '0;
        skid_valid_d   = 1'b0;
        skid_payload_d = '0;
        skid_w_req_d   = 1'b0;
        skid_w_addr_d  = '0;
      end else if (!main_valid_q) begin
        // Skid is always empty here; fill the head directly.
        if (accept) begin
          main_valid_d   = 1'b1;
          main_payload_d = in_payload;
          main_w_req_d   = cap_w_req;
          main_w_addr_d  = in_w_addr;
        end
      end else if (!skid_valid_q) begin
        if (accept && consume) begin
          main_payload_d = in_payload;
          main_w_req_d   = cap_w_req;
          main_w_addr_d  = in_w_addr;
        end else if (accept) begin
          skid_valid_d   = 1'b1;
          skid_payload_d = in_payload;
          skid_w_req_d   = cap_w_req;
          skid_w_addr_d  = in_w_addr;
        end else if (consume) begin
          main_valid_d   = 1'b0;
          main_payload_d = NOP_PAYLOAD;
          main_w_req_d   = 1'b0;
          main_w_addr_d  = '0;
        end
      end else if (consume) begin
        // Both full: in_ready is low, so only a skid-to-head shift can happen.
        main_payload_d = skid_payload_q;
        main_w_req_d   = skid_w_req_q;
        main_w_addr_d  = skid_w_addr_q;
        skid_valid_d   = 1'b0;
        skid_payload_d = '0;
        skid_w_req_d   = 1'b0;
        skid_w_addr_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q   <= 1'b0;
      main_payload_q <= NOP_PAYLOAD;
      main_w_req_q   <= 1'b0;
      main_w_addr_q  <= '0;
      skid_valid_q   <= 1'b0;
      skid_payload_q <= '0;
      skid_w_req_q   <= 1'b0;
      skid_w_addr_q  <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      main_valid_q   <= main_valid_d;
      main_payload_q <= main_payload_d;
      main_w_req_q   <= main_w_req_d;
      main_w_addr_q  <= main_w_addr_d;
      skid_valid_q   <= skid_valid_d;
      skid_payload_q <= skid_payload_d;
      skid_w_req_q   <= skid_w_req_d;
      skid_w_addr_q  <= skid_w_addr_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_payload = main_payload_q;
  assign out_w_req   = main_w_req_q;
  assign out_w_addr  = main_w_addr_q;
  assign occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign bubble_cnt  = bubble_cnt_q;

  // A held skid entry with an empty head would break FIFO order.
  skid_implies_main_a: assert property (@(posedge clk) disable iff (rst)
    main_valid_q || !skid_valid_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned PW = 96;
  localparam int unsigned AW = 5;
  localparam logic [PW-1:0] NOP = 96'h0000_0000_0000_0000_dead_beef;

  logic          clk = 1'b0;
  logic          rst, rdy, flush, in_valid, out_ready, in_w_req;
  logic [PW-1:0] in_payload;
  logic [AW-1:0] in_w_addr;

  logic          in_ready, out_valid, out_w_req;
  logic [PW-1:0] out_payload;
  logic [AW-1:0] out_w_addr;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;

  logic          in_ready2, out_valid2, out_w_req2;
  logic [PW-1:0] out_payload2;
  logic [AW-1:0] out_w_addr2;
  logic [1:0]    occupancy2;
  logic [1:0]    bubble_cnt2;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .PAYLOAD_W(PW), .REG_ADDR_W(AW), .NOP_PAYLOAD(NOP), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_w_req(in_w_req), .in_w_addr(in_w_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_w_req(out_w_req), .out_w_addr(out_w_addr),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance for the saturation corner.
  pipe_stage_skid #(
    .PAYLOAD_W(PW), .REG_ADDR_W(AW), .NOP_PAYLOAD(NOP), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_payload(in_payload),
    .in_w_req(in_w_req), .in_w_addr(in_w_addr),
    .out_valid(out_valid2), .out_ready(out_ready), .out_payload(out_payload2),
    .out_w_req(out_w_req2), .out_w_addr(out_w_addr2),
    .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
  );

  typedef struct {
    logic          rdy, flush, iv, ordy;
    logic [PW-1:0] pl;
    logic          wr;
    logic [AW-1:0] wa;
    logic          exp_ir;
    logic [1:0]    exp_occ;
  } vec_t;

  typedef struct {
    logic [PW-1:0] pl;
    logic          wr;
    logic [AW-1:0] wa;
  } ent_t;

  ent_t        sb[$];
  int unsigned bub;
  logic [1:0]  bub2;
  int          tests = 0;
  int          fails = 0;
  vec_t        vt[$];

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic ordy,
                              input logic [PW-1:0] pl, input logic wr, input logic [AW-1:0] wa,
                              input logic ir, input logic [1:0] occ);
    vec_t v;
    v.rdy = r; v.flush = f; v.iv = iv; v.ordy = ordy;
    v.pl = pl; v.wr = wr; v.wa = wa; v.exp_ir = ir; v.exp_occ = occ;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic model_ir();
    return rdy && !flush && (sb.size() < 2);
  endfunction

  // Compare both instances against the queue-based reference.
  task automatic check_state(input string tag);
    logic          ev;
    logic [PW-1:0] ep;
    logic          ew;
    logic [AW-1:0] ea;
    ev = sb.size() > 0;
    ep = ev ? sb[0].pl : NOP;
    ew = ev ? sb[0].wr : 1'b0;
    ea = ev ? sb[0].wa : '0;
    chk({tag, " out_valid"},   out_valid,   ev);
    chk({tag, " out_payload"}, out_payload, ep);
    chk({tag, " out_w_req"},   out_w_req,   ew);
    chk({tag, " out_w_addr"},  out_w_addr,  ea);
    chk({tag, " occupancy"},   occupancy,   sb.size());
    chk({tag, " in_ready"},    in_ready,    model_ir());
    chk({tag, " bubble_cnt"},  bubble_cnt,  bub[15:0]);
    chk({tag, " out_valid2"},  out_valid2,  ev);
    chk({tag, " out_payload2"}, out_payload2, ep);
    chk({tag, " out_w_req2"},  out_w_req2,  ew);
    chk({tag, " out_w_addr2"}, out_w_addr2, ea);
    chk({tag, " occupancy2"},  occupancy2,  sb.size());
    chk({tag, " in_ready2"},   in_ready2,   model_ir());
    chk({tag, " bubble_cnt2"}, bubble_cnt2, bub2);
  endtask

  // Reference next state, evaluated just before the clock edge.
  task automatic model_edge();
    logic acc, cons;
    ent_t e;
    if (rdy) begin
      if (sb.size() == 0) begin
        if (bub < 32'hFFFF) bub++;
        if (bub2 != 2'b11) bub2 = bub2 + 2'd1;
      end
      if (flush) begin
        sb.delete();
      end else begin
        acc  = in_valid && model_ir();
        cons = (sb.size() > 0) && out_ready;
        if (cons) void'(sb.pop_front());
        if (acc) begin
          e.pl = in_payload;
          e.wr = in_w_req && (in_w_addr != '0);
          e.wa = in_w_addr;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    bub  = 0;
    bub2 = 2'd0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    rdy = v.rdy; flush = v.flush; in_valid = v.iv; out_ready = v.ordy;
    in_payload = v.pl; in_w_req = v.wr; in_w_addr = v.wa;
    #1;
    chk($sformatf("vec%0d in_ready", idx), in_ready, v.exp_ir);
    check_state($sformatf("vec%0d pre", idx));
    model_edge();
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d occupancy", idx), occupancy, v.exp_occ);
    check_state($sformatf("vec%0d post", idx));
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_payload = '0; in_w_req = 1'b0; in_w_addr = '0;
    model_reset();
    #3 rst = 1'b1;
    #1;
    check_state("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    //       rdy  fl   iv   ordy payload   wr   wa     ir   occ
    // streaming A..D
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 96'hA, 1'b1, 5'd3, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 96'hB, 1'b0, 5'd4, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 96'hC, 1'b1, 5'd7, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 96'hD, 1'b0, 5'd0, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 96'h0, 1'b0, 5'd0, 1'b1, 2'd0));
    // backpressure A2,B2 held, C2 waits upstream
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'hA2, 1'b1, 5'd1, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'hB2, 1'b1, 5'd2, 1'b1, 2'd2));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'hC2, 1'b1, 5'd9, 1'b0, 2'd2));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 96'hC2, 1'b1, 5'd9, 1'b0, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 96'hC2, 1'b1, 5'd9, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 96'h0, 1'b0, 5'd0, 1'b1, 2'd0));
    // x0 squash then real write to x5
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'hE, 1'b1, 5'd0, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 96'hF, 1'b1, 5'd5, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 96'h0, 1'b0, 5'd0, 1'b1, 2'd0));
    // flush with two held and a new entry offered
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'h61, 1'b1, 5'd6, 1'b1, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'h62, 1'b1, 5'd8, 1'b1, 2'd2));
    vt.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 96'h63, 1'b1, 5'd10, 1'b0, 2'd0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 96'h0, 1'b0, 5'd0, 1'b1, 2'd0));
    // rdy freeze with an entry held, then fill to two
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'h71, 1'b1, 5'd11, 1'b1, 2'd1));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 96'h72, 1'b1, 5'd12, 1'b0, 2'd1));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 96'h72, 1'b1, 5'd12, 1'b0, 2'd1));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 96'h72, 1'b1, 5'd12, 1'b0, 2'd1));
    vt.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 96'h72, 1'b1, 5'd12, 1'b1, 2'd2));

    foreach (vt[i]) apply(vt[i], i);

    // Async reset mid-cycle with two entries held: outputs clear before any edge.
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst out_valid",   out_valid,   1'b0);
    chk("async_rst out_payload", out_payload, NOP);
    chk("async_rst out_w_req",   out_w_req,   1'b0);
    chk("async_rst out_w_addr",  out_w_addr,  5'd0);
    chk("async_rst occupancy",   occupancy,   2'd0);
    chk("async_rst bubble_cnt",  bubble_cnt,  16'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle cycles: 2-bit counter must stop at 3, wide counter keeps going.
    for (int i = 0; i < 5; i++) begin
      apply(mk(1'b1, 1'b0, 1'b0, 1'b1, 96'h0, 1'b0, 5'd0, 1'b1, 2'd0), 100 + i);
      if (i == 2) chk("bubble2 at 3 idle", bubble_cnt2, 2'd3);
    end
    chk("bubble2 saturated", bubble_cnt2, 2'd3);
    chk("bubble wide", bubble_cnt, 16'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
